// File: rtl/spi_ram_pkg.sv
// Shared opcodes, FSM states and response constants for the SPI RAM controller.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    READ_WAIT = 2'b01,
    RESPOND   = 2'b10
  } state_e;

  // Value driven on tx_data until the first read response after reset.
  localparam logic [17:0] TX_IDLE_WORD = 18'h3FFFF;

  // Tag prepended to every read response word.
  localparam logic [1:0]  RESP_TAG     = 2'b11;

endpackage

// File: rtl/spi_ram_mem.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module spi_ram_mem #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

  // Write on we, registered read on re (one cycle latency).
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder sitting behind the SPI slave: write/read address counters,
// RAM access and the read-response handshake back to the slave's tx path.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic        sys_clock,
  input  logic        reset_n,
  input  logic [17:0] rx_data,
  input  logic        rx_valid,
  output logic [17:0] tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        overrun
);

  state_e                state_q;
  logic                  rx_valid_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [17:0]           tx_data_q;
  logic                  tx_valid_q;
  logic                  busy_q;
  logic                  overrun_q;

  logic                  cmd_stb;
  logic                  cmd_accept;
  opcode_e               opcode;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // One command per rising edge of rx_valid; only accepted while idle.
  assign cmd_stb    = rx_valid & ~rx_valid_q;
  assign cmd_accept = cmd_stb & (state_q == IDLE);
  assign opcode     = opcode_e'(rx_data[17:16]);
  assign mem_we     = cmd_accept & (opcode == OP_WR_DATA);
  assign mem_re     = cmd_accept & (opcode == OP_RD_DATA);

  spi_ram_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (sys_clock),
    .we    (mem_we),
    .waddr (wr_addr_q),
    .wdata (rx_data[DATA_WIDTH-1:0]),
    .re    (mem_re),
    .raddr (rd_addr_q),
    .rdata (mem_rdata)
  );

  // Command decode, address counters, response FSM and registered outputs.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rx_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      tx_data_q  <= TX_IDLE_WORD;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      case (state_q)
        IDLE: begin
          if (cmd_stb) begin
            case (opcode)
              OP_WR_ADDR: wr_addr_q <= rx_data[ADDR_WIDTH-1:0];
              OP_WR_DATA: wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
              OP_RD_ADDR: rd_addr_q <= rx_data[ADDR_WIDTH-1:0];
              OP_RD_DATA: begin
                rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
                busy_q    <= 1'b1;
                state_q   <= READ_WAIT;
              end
            endcase
          end
        end
        READ_WAIT: begin
          tx_data_q  <= {RESP_TAG, mem_rdata};
          tx_valid_q <= 1'b1;
          state_q    <= RESPOND;
        end
        RESPOND: begin
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // A strobe arriving mid-response is dropped and flagged until reset.
      if (cmd_stb && (state_q != IDLE)) overrun_q <= 1'b1;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl with a behavioural RAM/pointer model.
module tb_spi_ram_ctrl;

  logic        sys_clock = 1'b0;
  logic        reset_n   = 1'b0;
  logic [17:0] rx_data   = '0;
  logic        rx_valid  = 1'b0;
  logic [17:0] tx_data;
  logic        tx_valid;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  // Reference model: memory image and the two address pointers.
  logic [15:0] mem_m [256];
  int          wr_addr_m = 0;
  int          rd_addr_m = 0;

  spi_ram_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .sys_clock (sys_clock),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 sys_clock = ~sys_clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic model_apply(input logic [1:0] op, input logic [15:0] pl);
    case (op)
      2'b00: wr_addr_m = int'(pl[7:0]);
      2'b01: begin mem_m[wr_addr_m] = pl; wr_addr_m = (wr_addr_m + 1) % 256; end
      2'b10: rd_addr_m = int'(pl[7:0]);
      default: ;
    endcase
  endtask

  // Issue a non-read command holding rx_valid for 'hold' cycles.
  task automatic send(input logic [1:0] op, input logic [15:0] pl, input int hold);
    @(negedge sys_clock);
    rx_data  = {op, pl};
    rx_valid = 1'b1;
    repeat (hold) @(negedge sys_clock);
    rx_valid = 1'b0;
    model_apply(op, pl);
  endtask

  // Issue RD_DATA and check timing, busy window, data and hold.
  task automatic read_chk(input string tag, input logic [17:0] exp);
    int nvalid = 0;
    int nbusy  = 0;
    int at     = -1;
    logic [17:0] got = '0;
    @(negedge sys_clock);
    rx_data  = {2'b11, 16'($urandom)};
    rx_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge sys_clock);
      if (k == 1) rx_valid = 1'b0;
      if (tx_valid) begin nvalid++; at = k; got = tx_data; end
      if (busy) nbusy++;
    end
    chk({tag, ".pulses"}, 18'(nvalid), 18'd1);
    chk({tag, ".latency"}, 18'(at), 18'd2);
    chk({tag, ".data"}, got, exp);
    chk({tag, ".busy_cycles"}, 18'(nbusy), 18'd2);
    chk({tag, ".hold"}, tx_data, exp);
    rd_addr_m = (rd_addr_m + 1) % 256;
  endtask

  initial begin
    logic [1:0]  op;
    logic [15:0] pl;
    int          wa;

    // Reset state and quiet idle period.
    #12;
    chk("rst.tx_data", tx_data, 18'h3FFFF);
    chk("rst.tx_valid", 18'(tx_valid), 18'd0);
    chk("rst.busy", 18'(busy), 18'd0);
    chk("rst.overrun", 18'(overrun), 18'd0);
    @(negedge sys_clock);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clock);
      chk("idle.word", {tx_valid, busy, overrun, 15'd0}, 18'd0);
      chk("idle.tx_data", tx_data, 18'h3FFFF);
    end

    // Fill the whole RAM with random data so every read is defined.
    send(2'b00, 16'h0000, 1);
    for (int i = 0; i < 256; i++) send(2'b01, 16'($urandom), 1);

    // Write/read round trip.
    send(2'b00, 16'h0005, 1);
    send(2'b01, 16'hBEEF, 1);
    send(2'b10, 16'h0005, 1);
    read_chk("roundtrip", 18'h3BEEF);

    // Auto-increment wrapping from the top address to zero.
    send(2'b00, 16'h00FF, 1);
    send(2'b01, 16'h1111, 1);
    send(2'b01, 16'h2222, 1);
    send(2'b10, 16'h00FF, 1);
    read_chk("wrap.ff", 18'h31111);
    read_chk("wrap.00", 18'h32222);
    send(2'b10, 16'h0000, 1);
    read_chk("wrap.addr0", 18'h32222);

    // Long rx_valid strobe yields a single write; upper payload bits ignored.
    send(2'b00, 16'hAB03, 1);
    send(2'b01, 16'hAAAA, 4);
    send(2'b01, 16'h1234, 1);
    send(2'b10, 16'h0003, 1);
    read_chk("long.mem3", 18'h3AAAA);
    read_chk("long.mem4", 18'h31234);
    read_chk("long.mem5", {2'b11, mem_m[5]});

    // Randomised command mix against the model.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      pl = 16'($urandom);
      if (op == 2'b11) read_chk("rand", {2'b11, mem_m[rd_addr_m]});
      else send(op, pl, int'($urandom_range(1, 3)));
    end
    chk("no_overrun_yet", 18'(overrun), 18'd0);

    // Overrun: a WR_ADDR strobe during a response is dropped.
    send(2'b00, 16'h0020, 1);
    wa = wr_addr_m;
    @(negedge sys_clock);
    rx_data  = {2'b11, 16'h0000};
    rx_valid = 1'b1;
    @(negedge sys_clock);
    rx_valid = 1'b0;
    chk("ovr.busy", 18'(busy), 18'd1);
    @(negedge sys_clock);
    chk("ovr.tx_valid", 18'(tx_valid), 18'd1);
    chk("ovr.tx_data", tx_data, {2'b11, mem_m[rd_addr_m]});
    rd_addr_m = (rd_addr_m + 1) % 256;
    rx_data  = {2'b00, 16'h0010};
    rx_valid = 1'b1;
    @(negedge sys_clock);
    rx_valid = 1'b0;
    chk("ovr.flag", 18'(overrun), 18'd1);
    chk("ovr.tx_valid_end", 18'(tx_valid), 18'd0);
    chk("ovr.busy_end", 18'(busy), 18'd0);
    send(2'b01, 16'h5A5A, 1);
    send(2'b10, 16'(wa), 1);
    read_chk("ovr.wr_addr_kept", 18'h35A5A);
    repeat (5) @(negedge sys_clock);
    chk("ovr.sticky", 18'(overrun), 18'd1);

    // Reset in the middle of a read discards the response.
    @(negedge sys_clock);
    rx_data  = {2'b11, 16'h0000};
    rx_valid = 1'b1;
    @(negedge sys_clock);
    rx_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("midrst.tx_data", tx_data, 18'h3FFFF);
    chk("midrst.tx_valid", 18'(tx_valid), 18'd0);
    chk("midrst.busy", 18'(busy), 18'd0);
    chk("midrst.overrun", 18'(overrun), 18'd0);
    repeat (2) @(negedge sys_clock);
    reset_n = 1'b1;
    wr_addr_m = 0;
    rd_addr_m = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clock);
      chk("midrst.no_pulse", 18'(tx_valid), 18'd0);
      chk("midrst.tx_hold", tx_data, 18'h3FFFF);
    end
    read_chk("postrst.addr0", {2'b11, mem_m[0]});
    send(2'b01, 16'hC0DE, 1);
    send(2'b10, 16'h0000, 1);
    read_chk("postrst.wr0", 18'h3C0DE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Command/data controller directly downstream of the SPI slave.
- Consumes each 18-bit received word (rx_data/rx_valid), decodes a 2-bit opcode, and performs write-address, write-data, read-address or read-data operations on an internal synchronous RAM.
- For read-data commands, returns the read word to the slave's transmit path (tx_data/tx_valid) for shifting out on MISO in the next SPI frame.

Parameters:
- ADDR_WIDTH, 8, RAM address width; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 16, RAM word width; must equal 16 (payload field width).

Ports:
- sys_clock  input  1  system clock.
- reset_n  input  1  reset; asynchronous, active-low.
- rx_data  input  18  received word from SPI slave; [17:16] opcode, [15:0] payload.
- rx_valid  input  1  received-word strobe from SPI slave; may stay high for more than one cycle.
- tx_data  output  18  response word to SPI slave ram_data_in; {2'b11, read data}.
- tx_valid  output  1  one-cycle strobe; tx_data is valid on its rising edge.
- busy  output  1  high while a read-data response is in flight.
- overrun  output  1  sticky; set when a command is dropped because busy was high.

Behaviour:
- Reset (async, reset_n low):
  - tx_data = 18'h3FFFF; tx_valid = 0; busy = 0; overrun = 0.
  - wr_addr = 0; rd_addr = 0; state = IDLE; rx_valid_q = 0.
  - RAM contents are not reset.
- Command detect: cmd_stb = rx_valid & ~rx_valid_q, where rx_valid_q is rx_valid registered on sys_clock.
  - Exactly one command per rx_valid rising edge, regardless of how long rx_valid stays high.
- Opcode decode, all taking effect at the clock edge where cmd_stb = 1 (edge N):
  - 2'b00 WR_ADDR: wr_addr <= payload[ADDR_WIDTH-1:0]. Upper payload bits are ignored.
  - 2'b01 WR_DATA: mem[wr_addr] <= payload; wr_addr <= wr_addr + 1, wrapping from 2**ADDR_WIDTH-1 to 0.
  - 2'b10 RD_ADDR: rd_addr <= payload[ADDR_WIDTH-1:0].
  - 2'b11 RD_DATA: issue RAM read at rd_addr; rd_addr <= rd_addr + 1 (wraps); state -> READ_WAIT; busy = 1 after edge N. Payload is ignored.
- FSM states: IDLE, READ_WAIT, RESPOND.
  - IDLE: accepts commands; RD_DATA -> READ_WAIT; all other opcodes stay in IDLE.
  - READ_WAIT (edge N+1): tx_data <= {2'b11, rdata}; tx_valid <= 1; state -> RESPOND.
  - RESPOND (edge N+2): tx_valid <= 0; busy <= 0; state -> IDLE.
- Latency and hold:
  - RD_DATA command to tx_valid high is 2 cycles.
  - tx_valid is high for exactly 1 cycle.
  - tx_data holds its value after the pulse until the next read response; it is never returned to all-ones except by reset.
- Busy collision: cmd_stb while state is not IDLE -> command fully dropped (no address, RAM or tx change); overrun <= 1 (sticky until reset).
- Write-then-read same address: a WR_DATA at edge N followed by RD_DATA at edge M > N returns the new data (no stale read).
- Reset mid-read: outputs return to reset values immediately; the pending response is discarded; tx_valid does not pulse after reset release.
- RAM: simple dual-port, one write port and one registered read port, 1-cycle read latency, no read-during-write bypass needed. Same-edge write and read cannot occur, because only one command is issued per edge.

Decomposition:
- Package spi_ram_pkg:
  - opcode localparams/enum: OP_WR_ADDR = 2'b00, OP_WR_DATA = 2'b01, OP_RD_ADDR = 2'b10, OP_RD_DATA = 2'b11.
  - FSM state enum: IDLE, READ_WAIT, RESPOND.
  - TX_IDLE_WORD = 18'h3FFFF.
  - RESP_TAG = 2'b11.
- Sub-module spi_ram_mem, parameterised by ADDR_WIDTH and DATA_WIDTH:
  - ports: clk, we, waddr, wdata, re, raddr, rdata.
  - registered read, no reset.
- spi_ram_ctrl: edge detect, decode, address counters, FSM and output registers.

Test Plan:
- Reset check: reset_n low -> tx_data = 18'h3FFFF, tx_valid = 0, busy = 0, overrun = 0. Release reset, 10 idle cycles -> no change.
- Write/read round trip:
  - Stimulus: WR_ADDR 0x0005, WR_DATA 0xBEEF, RD_ADDR 0x0005, RD_DATA.
  - Required: tx_valid pulses exactly 2 cycles after the RD_DATA strobe; tx_data = 18'h3BEEF; busy high for 2 cycles.
- Auto-increment and wrap:
  - Stimulus: WR_ADDR 0x00FF, WR_DATA 0x1111, WR_DATA 0x2222, then RD_ADDR 0x00FF, RD_DATA, RD_DATA.
  - Required: responses 18'h31111, then 18'h32222, the second read coming from address 0x00.
- Long strobe: rx_valid held high 4 cycles with WR_DATA 0xAAAA at wr_addr 3 -> only mem[3] is written; wr_addr = 4 afterwards.
- Overrun: RD_DATA, then a WR_ADDR 0x0010 strobe 1 cycle later -> WR_ADDR is ignored (wr_addr unchanged); overrun = 1 and stays 1; the read response still completes.
- Reset mid-read: RD_DATA, then assert reset_n 1 cycle later -> tx_valid never pulses; tx_data = 18'h3FFFF; busy = 0.
